// File: rtl/cmp_sched_pkg.sv
// Shared types and the round-robin search for the shared compare scheduler.
package cmp_sched_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_N_REQ      = 4;
  localparam int MAX_REQ        = 16;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_res_t;

  // Returns the first requester after ptr (wrapping at n) with req set; ptr if none.
  function automatic logic [3:0] rr_next(input logic [3:0] ptr,
                                         input logic [MAX_REQ-1:0] req,
                                         input int n);
    int   j;
    logic found;
    rr_next = ptr;
    found   = 1'b0;
    j       = 0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      if (k <= n && !found) begin
        j = (int'(ptr) + k) % n;
        if (req[j[3:0]]) begin
          rr_next = 4'(j);
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1, grant gated by en.
module rr_arbiter
  import cmp_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx
);

  logic [MAX_REQ-1:0] req_ext;
  logic [3:0]         ptr_ext;
  logic [3:0]         idx;

  always_comb begin
    req_ext              = '0;
    req_ext[N_REQ-1:0]   = req;
    ptr_ext              = 4'(ptr);
    idx                  = rr_next(ptr_ext, req_ext, N_REQ);
    grant_idx            = ID_W'(idx);
    grant                = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant[i] = en && req[i] && (idx == 4'(i));
    end
  end

endmodule

// File: rtl/cmp_rr_scheduler.sv
// One unsigned magnitude comparator shared by N_REQ requesters through a
// round-robin arbiter and a two-stage (operand, result) valid/ready pipeline.
module cmp_rr_scheduler
  import cmp_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_REQ      = DEF_N_REQ,
  parameter int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [N_REQ-1:0]            req_valid_in,
  output logic [N_REQ-1:0]            req_ready_out,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_a_in,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_b_in,
  output logic                        rsp_valid_out,
  input  logic                        rsp_ready_in,
  output logic [ID_W-1:0]             rsp_id_out,
  output logic                        a_g_b_out,
  output logic                        a_e_b_out,
  output logic                        a_l_b_out,
  output logic                        busy_out
);

  function automatic cmp_res_t mag_cmp(input logic [DATA_WIDTH-1:0] a,
                                       input logic [DATA_WIDTH-1:0] b);
    cmp_res_t r;
    r.gt = (a > b);
    r.eq = (a == b);
    r.lt = (a < b);
    return r;
  endfunction

  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_a_q, s1_a_d;
  logic [DATA_WIDTH-1:0] s1_b_q, s1_b_d;
  logic [ID_W-1:0]       s1_id_q, s1_id_d;
  logic                  s2_valid_q, s2_valid_d;
  cmp_res_t              s2_res_q, s2_res_d;
  logic [ID_W-1:0]       s2_id_q, s2_id_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;

  logic                  s1_load;
  logic                  s2_load;
  logic [N_REQ-1:0]      grant;
  logic [ID_W-1:0]       grant_idx;
  logic [DATA_WIDTH-1:0] gnt_a;
  logic [DATA_WIDTH-1:0] gnt_b;

  rr_arbiter #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .req      (req_valid_in),
    .ptr      (rr_ptr_q),
    .en       (s1_load),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  // Accepts are suppressed while reset is held so every output reads 0.
  always_comb begin
    s2_load = s1_valid_q && (!s2_valid_q || rsp_ready_in);
    s1_load = !rst_in && (|req_valid_in) && (!s1_valid_q || s2_load);
    gnt_a   = req_a_in[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    gnt_b   = req_b_in[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Stage 1: operands of the granted requester.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    rr_ptr_d   = rr_ptr_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_a_d     = gnt_a;
      s1_b_d     = gnt_b;
      s1_id_d    = grant_idx;
      rr_ptr_d   = grant_idx;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2: registered compare result and tag.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_id_d    = s2_id_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_res_d   = mag_cmp(s1_a_q, s1_b_q);
      s2_id_d    = s1_id_q;
    end else if (rsp_ready_in) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_id_q    <= '0;
      s1_id_q    <= '0;
      rr_ptr_q   <= ID_W'(N_REQ - 1);
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_id_q    <= s2_id_d;
      s1_id_q    <= s1_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // Operand registers are only observed behind s1_valid_q, so they carry no reset.
  always_ff @(posedge clk_in) begin
    s1_a_q <= s1_a_d;
    s1_b_q <= s1_b_d;
  end

  assign req_ready_out = grant;
  assign rsp_valid_out = s2_valid_q;
  assign rsp_id_out    = s2_id_q;
  assign a_g_b_out     = s2_res_q.gt;
  assign a_e_b_out     = s2_res_q.eq;
  assign a_l_b_out     = s2_res_q.lt;
  assign busy_out      = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_cmp_rr_scheduler.sv
// Directed bench for cmp_rr_scheduler (DATA_WIDTH=8, N_REQ=4).
module tb_cmp_rr_scheduler;

  logic        clk_in;
  logic        rst_in;
  logic [3:0]  req_valid_in;
  logic [3:0]  req_ready_out;
  logic [31:0] req_a_in;
  logic [31:0] req_b_in;
  logic        rsp_valid_out;
  logic        rsp_ready_in;
  logic [1:0]  rsp_id_out;
  logic        a_g_b_out;
  logic        a_e_b_out;
  logic        a_l_b_out;
  logic        busy_out;

  int n_pass = 0;
  int n_tot  = 0;
  int n_fail = 0;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  cmp_rr_scheduler #(
    .DATA_WIDTH(8),
    .N_REQ     (4),
    .ID_W      (2)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .req_valid_in (req_valid_in),
    .req_ready_out(req_ready_out),
    .req_a_in     (req_a_in),
    .req_b_in     (req_b_in),
    .rsp_valid_out(rsp_valid_out),
    .rsp_ready_in (rsp_ready_in),
    .rsp_id_out   (rsp_id_out),
    .a_g_b_out    (a_g_b_out),
    .a_e_b_out    (a_e_b_out),
    .a_l_b_out    (a_l_b_out),
    .busy_out     (busy_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [1:0] id,
                         input logic [2:0] fl);
    chk({tag, ".valid"}, 32'(rsp_valid_out), 32'(v));
    if (v) begin
      chk({tag, ".id"}, 32'(rsp_id_out), 32'(id));
      chk({tag, ".flags"}, 32'({a_g_b_out, a_e_b_out, a_l_b_out}), 32'(fl));
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a_in[i*8 +: 8] = a;
    req_b_in[i*8 +: 8] = b;
  endtask

  task automatic do_reset();
    req_valid_in = 4'b0000;
    rsp_ready_in = 1'b0;
    rst_in       = 1'b1;
    #2;
    rst_in       = 1'b0;
    tick();
  endtask

  // Exactly one compare flag whenever a result is presented.
  always @(negedge clk_in) begin
    if (rsp_valid_out === 1'b1)
      chk("onehot", 32'($onehot({a_g_b_out, a_e_b_out, a_l_b_out})), 32'd1);
  end

  initial begin
    rst_in       = 1'b0;
    req_valid_in = 4'b0000;
    rsp_ready_in = 1'b0;
    req_a_in     = '0;
    req_b_in     = '0;
    #1 rst_in = 1'b1;
    #2;
    chk("rst.rsp_valid", 32'(rsp_valid_out), 32'd0);
    chk("rst.busy", 32'(busy_out), 32'd0);
    chk("rst.ready", 32'(req_ready_out), 32'd0);
    chk("rst.id", 32'(rsp_id_out), 32'd0);
    chk("rst.flags", 32'({a_g_b_out, a_e_b_out, a_l_b_out}), 32'd0);
    rst_in = 1'b0;
    tick();

    // Single request from requester 2
    set_op(2, 8'h35, 8'h12);
    req_valid_in = 4'b0100;
    rsp_ready_in = 1'b1;
    #1;
    chk("single.ready", 32'(req_ready_out), 32'h4);
    tick();
    req_valid_in = 4'b0000;
    #1;
    chk("single.busy_s1", 32'(busy_out), 32'd1);
    chk_rsp("single.T", 1'b0, 2'd0, 3'b000);
    tick();
    chk_rsp("single.T1", 1'b1, 2'd2, GT);
    tick();
    chk_rsp("single.drain", 1'b0, 2'd0, 3'b000);
    chk("single.idle", 32'(busy_out), 32'd0);

    // Fairness: all four valid, equal operands
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 8'h80, 8'h80);
    rsp_ready_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      req_valid_in = (k < 8) ? 4'b1111 : 4'b0000;
      #1;
      chk($sformatf("fair%0d.ready", k), 32'(req_ready_out),
          (k < 8) ? 32'(1 << (k % 4)) : 32'd0);
      if (k >= 2) chk_rsp($sformatf("fair%0d", k), 1'b1, 2'((k - 2) % 4), EQ);
      tick();
    end
    chk_rsp("fair.end", 1'b0, 2'd0, 3'b000);

    // Backpressure with distinct operands
    do_reset();
    set_op(0, 8'h10, 8'h20);
    set_op(1, 8'h30, 8'h30);
    set_op(2, 8'h50, 8'h40);
    set_op(3, 8'h01, 8'h02);
    req_valid_in = 4'b1111;
    rsp_ready_in = 1'b1;
    #1;
    chk("bp0.ready", 32'(req_ready_out), 32'h1);
    tick();
    req_valid_in = 4'b1110;
    rsp_ready_in = 1'b0;
    #1;
    chk("bp1.ready", 32'(req_ready_out), 32'h2);
    tick();
    req_valid_in = 4'b1100;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp_hold%0d.ready", c), 32'(req_ready_out), 32'd0);
      chk_rsp($sformatf("bp_hold%0d", c), 1'b1, 2'd0, LT);
      tick();
    end
    rsp_ready_in = 1'b1;
    #1;
    chk("bp_rel.ready", 32'(req_ready_out), 32'h4);
    chk_rsp("bp_rel", 1'b1, 2'd0, LT);
    tick();
    req_valid_in = 4'b1000;
    #1;
    chk("bp_d1.ready", 32'(req_ready_out), 32'h8);
    chk_rsp("bp_d1", 1'b1, 2'd1, EQ);
    tick();
    req_valid_in = 4'b0000;
    #1;
    chk_rsp("bp_d2", 1'b1, 2'd2, GT);
    tick();
    chk_rsp("bp_d3", 1'b1, 2'd3, LT);
    tick();
    chk_rsp("bp_d4", 1'b0, 2'd0, 3'b000);
    chk("bp_d4.busy", 32'(busy_out), 32'd0);

    // Pointer hold across a stall
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 8'h00, 8'h00);
    req_valid_in = 4'b0001;
    #1;
    chk("ph0.ready", 32'(req_ready_out), 32'h1);
    tick();
    req_valid_in = 4'b0010;
    #1;
    chk("ph1.ready", 32'(req_ready_out), 32'h2);
    tick();
    req_valid_in = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("ph_stall%0d.ready", c), 32'(req_ready_out), 32'd0);
      tick();
    end
    rsp_ready_in = 1'b1;
    #1;
    chk("ph_rel.ready", 32'(req_ready_out), 32'h8);
    chk_rsp("ph_rel", 1'b1, 2'd0, EQ);
    tick();
    req_valid_in = 4'b0010;
    #1;
    chk("ph_next.ready", 32'(req_ready_out), 32'h2);
    chk_rsp("ph_next", 1'b1, 2'd1, EQ);
    tick();
    req_valid_in = 4'b0000;
    #1;
    chk_rsp("ph_d1", 1'b1, 2'd3, EQ);
    tick();
    chk_rsp("ph_d2", 1'b1, 2'd1, EQ);
    tick();
    chk_rsp("ph_d3", 1'b0, 2'd0, 3'b000);

    // Boundary operand values
    do_reset();
    set_op(0, 8'h00, 8'hFF);
    set_op(1, 8'hFF, 8'h00);
    set_op(2, 8'hFF, 8'hFF);
    set_op(3, 8'h00, 8'h00);
    rsp_ready_in = 1'b1;
    req_valid_in = 4'b0001;
    #1;
    chk("bnd0.ready", 32'(req_ready_out), 32'h1);
    tick();
    req_valid_in = 4'b0010;
    #1;
    chk("bnd1.ready", 32'(req_ready_out), 32'h2);
    tick();
    req_valid_in = 4'b0100;
    #1;
    chk_rsp("bnd_00_ff", 1'b1, 2'd0, LT);
    tick();
    req_valid_in = 4'b1000;
    #1;
    chk_rsp("bnd_ff_00", 1'b1, 2'd1, GT);
    tick();
    req_valid_in = 4'b0000;
    #1;
    chk_rsp("bnd_ff_ff", 1'b1, 2'd2, EQ);
    tick();
    chk_rsp("bnd_00_00", 1'b1, 2'd3, EQ);
    tick();
    chk_rsp("bnd_end", 1'b0, 2'd0, 3'b000);

    // Reset asserted between edges with both stages full
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 8'h11, 8'h22);
    req_valid_in = 4'b1111;
    rsp_ready_in = 1'b0;
    tick();
    tick();
    #1;
    chk("mid.full_valid", 32'(rsp_valid_out), 32'd1);
    chk("mid.full_busy", 32'(busy_out), 32'd1);
    #1 rst_in = 1'b1;
    #1;
    chk("mid.rst_valid", 32'(rsp_valid_out), 32'd0);
    chk("mid.rst_busy", 32'(busy_out), 32'd0);
    chk("mid.rst_ready", 32'(req_ready_out), 32'd0);
    #3 rst_in = 1'b0;
    #1;
    chk("mid.rel_ready", 32'(req_ready_out), 32'h1);
    tick();
    rsp_ready_in = 1'b1;
    req_valid_in = 4'b0000;
    #1;
    chk("mid.rel_busy", 32'(busy_out), 32'd1);
    tick();
    chk_rsp("mid.first", 1'b1, 2'd0, LT);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
